// File: rtl/sdram_burst_responder_pkg.sv
// sdram_burst_responder_pkg
// Shared definitions for the SDRAM burst responder:
//   - state_e    : controller state encoding
//   - BURST_LEN  : words per cache line burst
//   - BIDX_W     : width of a word index within a burst
//   - bidx_inc   : index increment that wraps modulo BURST_LEN
package sdram_burst_responder_pkg;

    localparam int BURST_LEN = 4;
    localparam int BIDX_W    = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_FETCH  = 3'd1,
        RD_STREAM = 3'd2,
        WR_MEM    = 3'd3,
        WR_DONE   = 3'd4
    } state_e;

    // Next word index inside a line; natural 2-bit overflow gives the 3->0 wrap.
    function automatic logic [BIDX_W-1:0] bidx_inc(input logic [BIDX_W-1:0] idx);
        return idx + BIDX_W'(1);
    endfunction

endpackage

// File: rtl/sdram_burst_responder_line_buffer.sv
// burst_line_buffer
// Holds one cache line (BURST_LEN words) gathered from the backing memory
// and replays it with a registered read port.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (read register only)
//   wr_en/idx/data    : write one word into slot wr_idx
//   rd_en/idx         : load rd_data from slot rd_idx on the next rising edge
//   rd_data           : registered read data, 0 after reset
module burst_line_buffer
    import sdram_burst_responder_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BIDX_W-1:0] wr_idx,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_en,
    input  logic [BIDX_W-1:0] rd_idx,
    output logic [DW-1:0]     rd_data
);

    logic [DW-1:0] line_q [BURST_LEN];
    logic [DW-1:0] rd_data_q;

    // Line storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_q[wr_idx] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= line_q[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sdram_burst_responder.sv
// sdram_burst_responder
// Serves cache-line reads (critical word first, 4-word burst) and single-word
// masked writes from a cache-side SDRAM interface using a simple req/ack
// backing memory.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   sdram_req/addr/rw          : cache request, byte address, 1=line read
//   data_to_sdram, sdram_dqm   : write data and byte masks (1 = masked)
//   data_from_sdram, sdram_fill: burst read data and its valid strobe
//   sdram_wack                 : one-cycle write-complete pulse
//   mem_addr/req/we/wdata/be   : backing memory request (word address)
//   mem_rdata, mem_ack         : backing memory response
module sdram_burst_responder
    import sdram_burst_responder_pkg::*;
#(
    parameter int MEM_AW = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sdram_req,
    input  logic [31:0]       sdram_addr,
    input  logic              sdram_rw,
    input  logic [15:0]       data_to_sdram,
    input  logic [1:0]        sdram_dqm,
    output logic [15:0]       data_from_sdram,
    output logic              sdram_fill,
    output logic              sdram_wack,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_be,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    logic [BIDX_W-1:0] ptr_q, ptr_d;
    logic [BIDX_W-1:0] cnt_q, cnt_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic [1:0]        mem_be_q, mem_be_d;
    logic              fill_q, fill_d;
    logic              wack_q, wack_d;
    logic              ack_s;
    logic              buf_wr_en_s;
    logic              unused_addr_bits_s;

    // An ack only counts against a request we are actually presenting.
    assign ack_s = mem_ack & mem_req_q;

    // Address bits outside the memory window are intentionally ignored.
    assign unused_addr_bits_s = ^{sdram_addr[31:MEM_AW+1], sdram_addr[0]};

    // Next-state and next-output computation for the request controller.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        fill_d      = 1'b0;
        wack_d      = 1'b0;
        buf_wr_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (sdram_req) begin
                    mem_addr_d = sdram_addr[MEM_AW:1];
                    if (sdram_rw) begin
                        ptr_d     = sdram_addr[2:1];
                        cnt_d     = '0;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        state_d   = RD_FETCH;
                    end else begin
                        mem_wdata_d = data_to_sdram;
                        mem_be_d    = ~sdram_dqm;
                        // Fully masked write: nothing to store, acknowledge at once.
                        if (sdram_dqm == 2'b11) begin
                            wack_d  = 1'b1;
                            state_d = WR_DONE;
                        end else begin
                            mem_req_d = 1'b1;
                            mem_we_d  = 1'b1;
                            state_d   = WR_MEM;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_FETCH: begin
                if (ack_s) begin
                    buf_wr_en_s = 1'b1;
                    ptr_d       = bidx_inc(ptr_q);
                    cnt_d       = cnt_q + BIDX_W'(1);
                    // Drop the request for one cycle between words.
                    mem_req_d   = 1'b0;
                    mem_addr_d  = {mem_addr_q[MEM_AW-1:BIDX_W], bidx_inc(ptr_q)};
                    // ptr has wrapped back to the critical word; start streaming.
                    if (cnt_q == BIDX_W'(BURST_LEN - 1)) begin
                        fill_d  = 1'b1;
                        state_d = RD_STREAM;
                    end else begin
                        state_d = RD_FETCH;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            RD_STREAM: begin
                // cnt wrapped to 0 on entry; the first fill is already registered.
                if (cnt_q == BIDX_W'(BURST_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    fill_d = 1'b1;
                    ptr_d  = bidx_inc(ptr_q);
                    cnt_d  = cnt_q + BIDX_W'(1);
                end
            end
            WR_MEM: begin
                if (ack_s) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 2'b00;
                    wack_d    = 1'b1;
                    state_d   = WR_DONE;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            WR_DONE: begin
                // Wait for the requester to let go so one request is served once.
                if (!sdram_req) begin
                    state_d = IDLE;
                end else begin
                    state_d = WR_DONE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 16'h0000;
            mem_be_q    <= 2'b00;
            fill_q      <= 1'b0;
            wack_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            fill_q      <= fill_d;
            wack_q      <= wack_d;
        end
    end

    // Read index follows the next pointer so data lines up with sdram_fill.
    burst_line_buffer #(
        .DW (16)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (buf_wr_en_s),
        .wr_idx  (ptr_q),
        .wr_data (mem_rdata),
        .rd_en   (fill_d),
        .rd_idx  (ptr_d),
        .rd_data (data_from_sdram)
    );

    assign sdram_fill = fill_q;
    assign sdram_wack = wack_q;
    assign mem_addr   = mem_addr_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_sdram_burst_responder.sv
// tb_sdram_burst_responder
// Directed bench for sdram_burst_responder with a behavioural backing memory
// whose read data is base + word-in-line index and whose ack delay is set
// per step.
module tb_sdram_burst_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sdram_req;
    logic [31:0] sdram_addr;
    logic        sdram_rw;
    logic [15:0] data_to_sdram;
    logic [1:0]  sdram_dqm;
    logic [15:0] data_from_sdram;
    logic        sdram_fill;
    logic        sdram_wack;
    logic [24:0] mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    sdram_burst_responder #(.MEM_AW(25)) dut (
        .clk             (clk),
        .reset           (reset),
        .sdram_req       (sdram_req),
        .sdram_addr      (sdram_addr),
        .sdram_rw        (sdram_rw),
        .data_to_sdram   (data_to_sdram),
        .sdram_dqm       (sdram_dqm),
        .data_from_sdram (data_from_sdram),
        .sdram_fill      (sdram_fill),
        .sdram_wack      (sdram_wack),
        .mem_addr        (mem_addr),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .mem_be          (mem_be),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack)
    );

    always #5 clk = ~clk;

    // Backing memory model
    int          ack_delay = 0;
    logic [15:0] rd_base = 16'h0000;
    int          wait_cnt = 0;
    int          ack_total = 0;
    int          wr_total = 0;
    logic [24:0] ack_addr_log[$];
    logic [15:0] wr_data_log = 16'h0000;
    logic [1:0]  wr_be_log = 2'b00;
    logic [24:0] wr_addr_log = 25'd0;

    always @(negedge clk) begin
        if (!reset) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_base + {14'd0, mem_addr[1:0]};
                wait_cnt  = 0;
                ack_total++;
                ack_addr_log.push_back(mem_addr);
                if (mem_we) begin
                    wr_total++;
                    wr_data_log = mem_wdata;
                    wr_be_log   = mem_be;
                    wr_addr_log = mem_addr;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Output monitor
    int          cyc = 0;
    logic        last_ack_edge = 1'b0;
    logic [15:0] fill_data[$];
    int          fill_cyc[$];
    int          wack_total = 0;
    int          overlap_err = 0;
    int          b2b_err = 0;
    int          req_cycles = 0;

    always @(posedge clk) begin
        cyc++;
        last_ack_edge = mem_ack;
    end

    always @(negedge clk) begin
        if (reset) begin
            if (sdram_fill) begin
                fill_data.push_back(data_from_sdram);
                fill_cyc.push_back(cyc);
            end
            if (sdram_wack) wack_total++;
            if (sdram_fill && sdram_wack) overlap_err++;
            if (last_ack_edge && mem_req) b2b_err++;
            if (mem_req) req_cycles++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_read(input logic [31:0] addr, input int delay, input logic [15:0] base,
                            output int lat, output bit got);
        fill_data.delete();
        fill_cyc.delete();
        ack_addr_log.delete();
        ack_delay = delay;
        rd_base   = base;
        @(negedge clk);
        sdram_req  = 1'b1;
        sdram_rw   = 1'b1;
        sdram_addr = addr;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            if (sdram_fill) got = 1'b1;
        end
        sdram_req = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic verify_read(input string tag, input logic [63:0] ed, input logic [99:0] ea);
        logic [15:0] od;
        logic [24:0] oa;
        check({tag, "_nfill"}, fill_data.size(), 4);
        check({tag, "_nack"}, ack_addr_log.size(), 4);
        check({tag, "_consec"}, (fill_cyc.size() == 4) ? fill_cyc[3] - fill_cyc[0] : -1, 3);
        for (int i = 0; i < 4; i++) begin
            od = (i < fill_data.size()) ? fill_data[i] : 16'hFFFF;
            oa = (i < ack_addr_log.size()) ? ack_addr_log[i] : 25'h1FF_FFFF;
            check($sformatf("%s_data%0d", tag, i), od, ed[63-16*i -: 16]);
            check($sformatf("%s_addr%0d", tag, i), oa, ea[99-25*i -: 25]);
        end
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [15:0] data, input logic [1:0] dqm,
                             input int hold, output int wait_n, output bit got);
        @(negedge clk);
        sdram_req     = 1'b1;
        sdram_rw      = 1'b0;
        sdram_addr    = addr;
        data_to_sdram = data;
        sdram_dqm     = dqm;
        wait_n = 0;
        got = 1'b0;
        while (!got && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
            if (sdram_wack) got = 1'b1;
        end
        repeat (hold) @(negedge clk);
        sdram_req = 1'b0;
    endtask

    initial begin
        int lat;
        bit got;
        int wn;
        int a0, w0, k0, r0;
        reset = 1'b0;
        sdram_req = 1'b0;
        sdram_rw = 1'b0;
        sdram_addr = 32'd0;
        data_to_sdram = 16'h0000;
        sdram_dqm = 2'b00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outs", {data_from_sdram, sdram_fill, sdram_wack, mem_req, mem_we, mem_be, mem_wdata}, 64'd0);
        check("rst_maddr", mem_addr, 25'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Critical word 2, immediate acks
        run_read(32'h0000_1234, 0, 16'h1230, lat, got);
        check("rd1_got", got, 1'b1);
        check("rd1_lat_le12", (lat <= 12), 1'b1);
        verify_read("rd1", {16'h1232, 16'h1233, 16'h1230, 16'h1231},
                    {25'h91A, 25'h91B, 25'h918, 25'h919});

        // Critical word 3, acks delayed 5 cycles
        run_read(32'h0000_0A06, 5, 16'hA000, lat, got);
        check("rd2_got", got, 1'b1);
        verify_read("rd2", {16'hA003, 16'hA000, 16'hA001, 16'hA002},
                    {25'h503, 25'h500, 25'h501, 25'h502});

        // Masked write, request held 3 cycles past wack
        a0 = ack_total; w0 = wr_total; k0 = wack_total;
        ack_delay = 2;
        run_write(32'h0000_0100, 16'hBEEF, 2'b10, 3, wn, got);
        repeat (3) @(negedge clk);
        check("wr1_got", got, 1'b1);
        check("wr1_nwack", wack_total - k0, 1);
        check("wr1_nmem", ack_total - a0, 1);
        check("wr1_nwe", wr_total - w0, 1);
        check("wr1_be", wr_be_log, 2'b01);
        check("wr1_wdata", wr_data_log, 16'hBEEF);
        check("wr1_addr", wr_addr_log, 25'h080);

        // Fully masked write: no memory traffic, wack one cycle after acceptance
        a0 = ack_total; k0 = wack_total; r0 = req_cycles;
        run_write(32'h0000_0300, 16'hDEAD, 2'b11, 1, wn, got);
        repeat (3) @(negedge clk);
        check("wr2_wait", wn, 1);
        check("wr2_nwack", wack_total - k0, 1);
        check("wr2_nmem", ack_total - a0, 0);
        check("wr2_reqcyc", req_cycles - r0, 0);

        // Reset during the second word fetch
        fill_data.delete();
        k0 = wack_total;
        ack_delay = 3;
        rd_base = 16'h5550;
        @(negedge clk);
        sdram_req = 1'b1;
        sdram_rw = 1'b1;
        sdram_addr = 32'h0000_1234;
        got = 1'b0;
        wn = 0;
        while (!got && wn < 50) begin
            @(negedge clk);
            wn++;
            if (mem_req && mem_addr[1:0] == 2'd3) got = 1'b1;
        end
        check("mrst_reach", got, 1'b1);
        reset = 1'b0;
        sdram_req = 1'b0;
        #1;
        check("mrst_outs", {data_from_sdram, sdram_fill, sdram_wack, mem_req, mem_we, mem_be, mem_wdata}, 64'd0);
        check("mrst_maddr", mem_addr, 25'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("mrst_nofill", fill_data.size(), 0);
        check("mrst_nowack", wack_total - k0, 0);
        run_read(32'h0000_1234, 0, 16'h7770, lat, got);
        check("rd3_got", got, 1'b1);
        verify_read("rd3", {16'h7772, 16'h7773, 16'h7770, 16'h7771},
                    {25'h91A, 25'h91B, 25'h918, 25'h919});

        // Write with request held across WR_DONE, low one cycle, then read
        w0 = wr_total;
        ack_delay = 0;
        run_write(32'h0000_0200, 16'h1357, 2'b00, 2, wn, got);
        check("wr3_got", got, 1'b1);
        run_read(32'h0000_0002, 0, 16'h2460, lat, got);
        check("wr3_nwe", wr_total - w0, 1);
        check("wr3_be", wr_be_log, 2'b11);
        check("wr3_wdata", wr_data_log, 16'h1357);
        check("wr3_addr", wr_addr_log, 25'h100);
        check("rd4_got", got, 1'b1);
        verify_read("rd4", {16'h2461, 16'h2462, 16'h2463, 16'h2460},
                    {25'h001, 25'h002, 25'h003, 25'h000});

        // Whole-run properties
        check("fill_wack_overlap", overlap_err, 0);
        check("req_after_ack", b2b_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdram_burst_responder.md
SDRAM_BURST_RESPONDER -- requirements
Module: sdram_burst_responder

Interface
REQ-001 Parameter MEM_AW, 25, width of the 16-bit-word memory address; covers byte address bits [25:1].
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 sdram_req  in  1  request from the cache, held high until fill (read) or sdram_wack (write).
REQ-005 sdram_addr  in  32  byte address; [2:1] selects the critical word, [25:3] selects the line.
REQ-006 sdram_rw  in  1  1 = line read, 0 = single-word write.
REQ-007 data_to_sdram  in  16  write data.
REQ-008 sdram_dqm  in  2  byte masks, 1 = byte not written; [1] upper, [0] lower.
REQ-009 data_from_sdram  out  16  burst read data.
REQ-010 sdram_fill  out  1  high on each of the 4 burst data cycles.
REQ-011 sdram_wack  out  1  one-cycle write-complete pulse.
REQ-012 mem_addr  out  MEM_AW  word address to the backing memory.
REQ-013 mem_req  out  1  memory request, level held until mem_ack.
REQ-014 mem_we  out  1  1 = write transaction.
REQ-015 mem_wdata  out  16  memory write data.
REQ-016 mem_be  out  2  active-high byte enables; equal to ~sdram_dqm.
REQ-017 mem_rdata  in  16  memory read data, valid when mem_ack is high.
REQ-018 mem_ack  in  1  one-cycle completion pulse per transaction.

Function
REQ-019 States: IDLE, RD_FETCH, RD_STREAM, WR_MEM, WR_DONE.
REQ-020 IDLE, sdram_req=1, sdram_rw=1: latch the address, set ptr=addr[2:1] and cnt=0, then go to RD_FETCH.
REQ-021 IDLE, sdram_req=1, sdram_rw=0: latch address, data and dqm, then go to WR_MEM.
REQ-022 RD_FETCH: issue one mem read per word at {addr[25:3],ptr}; store mem_rdata in line buffer slot ptr on mem_ack.
REQ-023 On each mem_ack in RD_FETCH: ptr advances by 1 modulo 4 (wrap 3->0) and cnt increments.
REQ-024 The fourth mem_ack in RD_FETCH leaves ptr equal to the critical index and moves to RD_STREAM.
REQ-025 mem_req deasserts in the cycle after each mem_ack and reasserts one cycle later; no back-to-back requests.
REQ-026 RD_STREAM: sdram_fill=1 for exactly 4 consecutive cycles; data order crit, crit+1, crit+2, crit+3 (mod 4); then return to IDLE.
REQ-027 First fill cycle: data_from_sdram is the critical word; the requester may drop sdram_req from the next cycle.
REQ-028 sdram_req is ignored in RD_FETCH and RD_STREAM; a request is accepted again from IDLE only.
REQ-029 WR_MEM: mem_req=1, mem_we=1, mem_be=~dqm; on mem_ack, pulse sdram_wack for one cycle and go to WR_DONE.
REQ-030 dqm=2'b11: no mem transaction; sdram_wack pulses the cycle after acceptance.
REQ-031 WR_DONE: wait until sdram_req=0, then go to IDLE; this prevents a held request being accepted twice.
REQ-032 Read latency: fill starts 1 cycle after the fourth mem_ack; with 1-cycle mem_ack the worst case is 12 cycles from req.
REQ-033 Outputs are registered; sdram_fill and sdram_wack never assert in the same cycle.

Reset
REQ-034 Reset asserted returns state to IDLE and sets every output to 0, including mem_req, mem_we, fill, wack and data.
REQ-035 Reset mid-burst aborts the burst with no partial fill; line buffer contents after reset are don't-care.
REQ-036 After reset release, the first accepted request is serviced normally.

Structure
REQ-037 A shared package holds the state enumeration, BURST_LEN=4, and the burst index width of 2.
REQ-038 The 4x16 line buffer is one sub-module, burst_line_buffer, with 2-bit write and read indices and a registered read.

Verification
REQ-039 Read, addr=0x0000_1234 (crit=2), mem word n=0x1230+n: fill data 0x1232, 0x1233, 0x1230, 0x1231 on 4 consecutive cycles.
REQ-040 Read, crit=3, mem_ack delayed 5 cycles each: mem_addr sequence ends ...3, 0, 1, 2; 4 fill cycles; no request re-accepted.
REQ-041 Write data=0xBEEF, dqm=2'b10: mem_be=2'b01, mem_wdata=0xBEEF; exactly one wack; no second write while req is held 3 more cycles.
REQ-042 Write with dqm=2'b11: mem_req stays 0; wack pulses one cycle after acceptance.
REQ-043 Reset pulsed during the 2nd fetch: all outputs 0 at once; no fill; the next read completes correctly.
REQ-044 Read immediately after write (req held across WR_DONE, low 1 cycle, new read): 4 fill cycles, correct ordering.
